ps2_keypress_decoder: RTL

- Front end of the Tetris keyboard path: receives PS/2 keyboard frames and produces the 3-bit `keypress` command consumed by the block movement logic.
- Command codes: 0 none, 1 left, 2 right, 3 soft drop, 4 hard drop.
- Tracks make and break codes so `keypress` holds its value while the key is down and returns to 0 on release.
- Flags malformed frames; never drives a code from a bad frame.

---
 rtl/ps2_keypress_decoder.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_keypress_decoder.sv
// ps2_keypress_decoder: receives PS/2 keyboard frames and turns make/break
// scan codes into the 3-bit Tetris movement command (0 none, 1 left,
// 2 right, 3 soft drop, 4 hard drop).
// Optional macro ARROW_KEYS_EN: E0-prefixed arrow keys also map to
// left / right / soft drop. Without it, extended keys are ignored.
module ps2_keypress_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [2:0] keypress,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] TMO_ONE  = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // A frame is good when data bits plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  // Command code for a plain (non-extended) scan code.
  function automatic logic [2:0] map_std(input logic [7:0] code);
    case (code)
      8'h1C:   return 3'd1;
      8'h23:   return 3'd2;
      8'h1B:   return 3'd3;
      8'h29:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

`ifdef ARROW_KEYS_EN
  // Command code for a scan code that followed an E0 prefix.
  function automatic logic [2:0] map_ext(input logic [7:0] code);
    case (code)
      8'h6B:   return 3'd1;
      8'h74:   return 3'd2;
      8'h72:   return 3'd3;
      default: return 3'd0;
    endcase
  endfunction
`endif

  logic       ck_s1_q, ck_s2_q, ck_prev_q;
  logic       dt_s1_q, dt_s2_q;
  logic       fall_s;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          brk_q, brk_d;
  logic          ext_q, ext_d;
  logic [2:0]    key_q, key_d;
  logic          kv_q, kv_d;
  logic          fe_q, fe_d;
  logic [2:0]    code_s;
  logic          use_s;

  // Two-flop synchronizers for the PS/2 pads plus a history flop for edge detection.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ck_s1_q   <= 1'b1;
      ck_s2_q   <= 1'b1;
      ck_prev_q <= 1'b1;
      dt_s1_q   <= 1'b1;
      dt_s2_q   <= 1'b1;
    end else begin
      ck_s1_q   <= ps2_clk;
      ck_s2_q   <= ck_s1_q;
      ck_prev_q <= ck_s2_q;
      dt_s1_q   <= ps2_data;
      dt_s2_q   <= dt_s1_q;
    end
  end

  assign fall_s = ck_prev_q & ~ck_s2_q;

  // Frame FSM state, shift register, timeout counter, prefix flags and outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      tmo_q     <= TMO_ZERO;
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
      key_q     <= 3'd0;
      kv_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      brk_q     <= brk_d;
      ext_q     <= ext_d;
      key_q     <= key_d;
      kv_q      <= kv_d;
      fe_q      <= fe_d;
    end
  end

  // Next-state logic: frame reception, timeout, and make/break decode on the stop edge.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = tmo_q;
    brk_d     = brk_q;
    ext_d     = ext_q;
    key_d     = key_q;
    kv_d      = 1'b0;
    fe_d      = 1'b0;
    code_s    = 3'd0;
    use_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tmo_d = TMO_ZERO;
        // A high data bit at the edge is not a start bit; ignore it quietly.
        if (fall_s && !dt_s2_q) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DATA: begin
        if (fall_s) begin
          tmo_d     = TMO_ZERO;
          shift_d   = {dt_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            state_d = ST_DATA;
          end
        end else if (tmo_q == TMO_LAST) begin
          fe_d    = 1'b1;
          tmo_d   = TMO_ZERO;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end

      ST_PARITY: begin
        if (fall_s) begin
          tmo_d   = TMO_ZERO;
          par_d   = dt_s2_q;
          state_d = ST_STOP;
        end else if (tmo_q == TMO_LAST) begin
          fe_d    = 1'b1;
          tmo_d   = TMO_ZERO;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end

      ST_STOP: begin
        if (fall_s) begin
          tmo_d   = TMO_ZERO;
          state_d = ST_IDLE;
          if (dt_s2_q && odd_parity_ok(shift_q, par_q)) begin
            if (shift_q == 8'hF0) begin
              brk_d = 1'b1;
            end else if (shift_q == 8'hE0) begin
              ext_d = 1'b1;
            end else begin
              brk_d = 1'b0;
              ext_d = 1'b0;
              if (ext_q) begin
`ifdef ARROW_KEYS_EN
                code_s = map_ext(shift_q);
                use_s  = 1'b1;
`else
                code_s = 3'd0;
                use_s  = 1'b0;
`endif
              end else begin
                code_s = map_std(shift_q);
                use_s  = 1'b1;
              end
              if (!use_s) begin
                key_d = key_q;
              end else if (!brk_q) begin
                // Make: a repeat of the held key re-strobes key_valid.
                if (code_s != 3'd0) begin
                  key_d = code_s;
                  kv_d  = 1'b1;
                end else begin
                  key_d = key_q;
                end
              end else begin
                // Break: only releasing the currently shown key clears it.
                if (code_s == key_q) begin
                  key_d = 3'd0;
                end else begin
                  key_d = key_q;
                end
              end
            end
          end else begin
            fe_d  = 1'b1;
            brk_d = 1'b0;
            ext_d = 1'b0;
          end
        end else if (tmo_q == TMO_LAST) begin
          fe_d    = 1'b1;
          tmo_d   = TMO_ZERO;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        tmo_d   = TMO_ZERO;
      end
    endcase
  end

  assign keypress  = key_q;
  assign key_valid = kv_q;
  assign frame_err = fe_q;

endmodule
